tm_run_ctrl: RTL and testbench
==============================

TM_RUN_CTRL -- requirements
Module: tm_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 24, step-counter width.
REQ-002 SHALL have parameter HALT_STATE, default 7'h7D, TM state code meaning "machine halted".
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port cmd_valid_i  input  1  host command strobe, one cycle per command.
REQ-007 SHALL have port cmd_i  input  2  command: 0 CLEAR, 1 RUN, 2 STEP, 3 STOP.
REQ-008 SHALL have port cmd_err_o  output  1  one-cycle pulse, command rejected in current state.
REQ-009 SHALL have port step_en_o  output  1  level; core may start a new TM step only while high.
REQ-010 SHALL have port step_done_i  input  1  one-cycle pulse from core: tape move of a step completed.
REQ-011 SHALL have port tm_state_i  input  7  core's current TM state, valid with step_done_i.
REQ-012 SHALL have port bp_en_i  input  1  breakpoint enable.
REQ-013 SHALL have port bp_state_i  input  7  breakpoint TM state.
REQ-014 SHALL have port step_limit_i  input  CNT_W  step budget, 0 = unlimited.
REQ-015 SHALL have port step_cnt_o  output  CNT_W  steps completed since last CLEAR.
REQ-016 SHALL have port busy_o  output  1  high in RUN, STEP, DRAIN.
REQ-017 SHALL have port halt_reason_o  output  2  0 NONE, 1 HALT, 2 BREAK, 3 LIMIT.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, STEP, DRAIN, STOPPED.
REQ-019 IDLE: RUN->RUN, STEP->STEP, CLEAR->IDLE (counter 0, reason NONE), STOP->cmd_err_o.
REQ-020 STOPPED: same transitions as IDLE, except RUN/STEP with halt_reason_o==HALT -> cmd_err_o, no transition.
REQ-021 RUN/STEP: STOP->DRAIN; RUN, STEP, CLEAR -> cmd_err_o, no state change.
REQ-022 DRAIN: every command -> cmd_err_o.
REQ-023 step_en_o SHALL be registered; high only in RUN, and in STEP until the first step_done_i.
REQ-024 Each step_done_i in RUN, STEP or DRAIN SHALL increment step_cnt_o by 1, saturating at all-ones; saturation alone never stops.
REQ-025 On step_done_i, stop check SHALL use tm_state_i and the post-increment count, priority HALT (tm_state_i==HALT_STATE) > BREAK (bp_en_i && tm_state_i==bp_state_i) > LIMIT (step_limit_i!=0 && count>=step_limit_i).
REQ-026 A stop check match in RUN or STEP SHALL go to STOPPED, latch the reason, and drop step_en_o next cycle.
REQ-027 STEP with no match on step_done_i SHALL go to IDLE, reason NONE.
REQ-028 DRAIN SHALL hold step_en_o low and wait for step_done_i; then go to STOPPED with reason from REQ-025, or to IDLE if no match.
REQ-029 DRAIN SHALL have no timeout; a step in flight is never aborted.
REQ-030 step_done_i in IDLE or STOPPED SHALL be ignored: no count, no transition.
REQ-031 A STOP command in the same cycle as a matching step_done_i SHALL be absorbed: STOPPED with the match reason, no cmd_err_o.
REQ-032 RUN resumed from BREAK SHALL not re-trigger on the first step's entry state; only step_done_i results are checked.
REQ-033 halt_reason_o SHALL hold until CLEAR or the next accepted RUN/STEP, which set it to NONE.
REQ-034 cmd_err_o SHALL assert one cycle after the rejected command.
REQ-035 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-036 rst SHALL force: state IDLE, step_en_o 0, step_cnt_o 0, halt_reason_o NONE, busy_o 0, cmd_err_o 0.
REQ-037 rst mid-step SHALL not wait for step_done_i; the core SHALL be reset with the same rst.

Structure
REQ-038 Package tm_pkg SHALL hold the command codes, FSM state encoding, halt-reason codes and the default HALT_STATE.
REQ-039 Sub-module tm_step_counter SHALL hold the saturating counter and the limit compare; the rest is one FSM module.

Verification
REQ-040 RUN, core halts at step 5 with tm_state_i=7'h7D -> STOPPED, reason 1, step_cnt_o=5, step_en_o low next cycle.
REQ-041 bp_en_i=1, bp_state_i=7'h12, RUN, match at step 3 -> reason 2, count 3; RUN again -> resumes, count 4 on next done.
REQ-042 step_limit_i=10, RUN -> stop at count 10, reason 3; step_limit_i=0 with CNT_W=4 -> count saturates at 15, still running.
REQ-043 STEP from IDLE -> exactly one step, IDLE, count+1; STEP while in STEP -> cmd_err_o pulse.
REQ-044 STOP mid-step -> DRAIN, busy_o high until step_done_i, then IDLE; STOP together with HALT done -> reason 1, no error.
REQ-045 rst asserted in RUN -> all outputs at reset values next cycle; STOP in IDLE -> cmd_err_o pulse.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types for the Turing-machine run controller.
// Command codes, FSM state encoding, halt reasons, default halt state.
package tm_pkg;

   typedef enum logic [1:0] {
      CMD_CLEAR = 2'd0,
      CMD_RUN   = 2'd1,
      CMD_STEP  = 2'd2,
      CMD_STOP  = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_DRAIN,
      S_STOPPED
   } state_e;

   typedef enum logic [1:0] {
      RSN_NONE  = 2'd0,
      RSN_HALT  = 2'd1,
      RSN_BREAK = 2'd2,
      RSN_LIMIT = 2'd3
   } reason_e;

   localparam logic [6:0] HALT_STATE_DEF = 7'h7D;

endpackage

// File: rtl/tm_run_ctrl_if.sv
// Host command / core step bundle of the run controller.
// master: host+core side, slave: tm_run_ctrl.
interface tm_run_ctrl_if #(
   parameter int CNT_W = 24
);
   logic             cmd_valid_i;
   logic [1:0]       cmd_i;
   logic             cmd_err_o;
   logic             step_en_o;
   logic             step_done_i;
   logic [6:0]       tm_state_i;
   logic             bp_en_i;
   logic [6:0]       bp_state_i;
   logic [CNT_W-1:0] step_limit_i;
   logic [CNT_W-1:0] step_cnt_o;
   logic             busy_o;
   logic [1:0]       halt_reason_o;

   modport master (
      output cmd_valid_i, cmd_i, step_done_i, tm_state_i,
      output bp_en_i, bp_state_i, step_limit_i,
      input  cmd_err_o, step_en_o, step_cnt_o, busy_o, halt_reason_o
   );

   modport slave (
      input  cmd_valid_i, cmd_i, step_done_i, tm_state_i,
      input  bp_en_i, bp_state_i, step_limit_i,
      output cmd_err_o, step_en_o, step_cnt_o, busy_o, halt_reason_o
   );
endinterface

// File: rtl/tm_step_counter.sv
// Saturating step counter with step-budget compare.
// clr/inc control, cnt registered, cnt_nxt/limit_hit are post-increment.
module tm_step_counter #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             limit_hit
);

   // Value the counter will hold after the current step completes.
   assign cnt_nxt   = (&cnt) ? cnt : cnt + 1'b1;
   assign limit_hit = (limit != '0) && (cnt_nxt >= limit);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/tm_run_ctrl.sv
// Run/step/stop controller for a Turing-machine core.
// Ports: clk, rst, bus (host commands, core step handshake, status).
module tm_run_ctrl
   import tm_pkg::*;
#(
   parameter int         CNT_W      = 24,
   parameter logic [6:0] HALT_STATE = HALT_STATE_DEF
) (
   input  logic         clk,
   input  logic         rst,
   tm_run_ctrl_if.slave bus
);

   state_e           state, state_n;
   reason_e          reason, reason_n, match;
   logic             step_en, busy, err, err_n;
   logic             clr, inc, limit_hit;
   logic             is_stop;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   tm_step_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .inc       (inc),
      .limit     (bus.step_limit_i),
      .cnt       (cnt),
      .cnt_nxt   (cnt_nxt),
      .limit_hit (limit_hit)
   );

   assign is_stop = bus.cmd_valid_i && (bus.cmd_i == CMD_STOP);
   assign inc = bus.step_done_i &&
                (state == S_RUN || state == S_STEP || state == S_DRAIN);

   always_comb begin
      match = RSN_NONE;
      if (bus.tm_state_i == HALT_STATE)
         match = RSN_HALT;
      else if (bus.bp_en_i && bus.tm_state_i == bus.bp_state_i)
         match = RSN_BREAK;
      else if (limit_hit)
         match = RSN_LIMIT;
   end

   always_comb begin
      state_n  = state;
      reason_n = reason;
      err_n    = 1'b0;
      clr      = 1'b0;
      unique case (state)
         S_IDLE, S_STOPPED: begin
            if (bus.cmd_valid_i) begin
               unique case (bus.cmd_i)
                  CMD_CLEAR: begin
                     state_n  = S_IDLE;
                     reason_n = RSN_NONE;
                     clr      = 1'b1;
                  end
                  CMD_RUN, CMD_STEP: begin
                     // A halted machine cannot be restarted without CLEAR.
                     if (state == S_STOPPED && reason == RSN_HALT) begin
                        err_n = 1'b1;
                     end else begin
                        state_n  = (bus.cmd_i == CMD_RUN) ? S_RUN : S_STEP;
                        reason_n = RSN_NONE;
                     end
                  end
                  default: err_n = 1'b1;
               endcase
            end
         end
         S_RUN, S_STEP: begin
            if (bus.step_done_i) begin
               // STOP landing on a step boundary resolves immediately.
               if (match != RSN_NONE) begin
                  state_n  = S_STOPPED;
                  reason_n = match;
               end else if (state == S_STEP || is_stop) begin
                  state_n = S_IDLE;
               end
               err_n = bus.cmd_valid_i && !is_stop;
            end else if (bus.cmd_valid_i) begin
               if (is_stop) state_n = S_DRAIN;
               else err_n = 1'b1;
            end
         end
         S_DRAIN: begin
            err_n = bus.cmd_valid_i;
            if (bus.step_done_i) begin
               if (match != RSN_NONE) begin
                  state_n  = S_STOPPED;
                  reason_n = match;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         reason  <= RSN_NONE;
         step_en <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         reason  <= reason_n;
         step_en <= (state_n == S_RUN) || (state_n == S_STEP);
         busy    <= (state_n == S_RUN) || (state_n == S_STEP) ||
                    (state_n == S_DRAIN);
         err     <= err_n;
      end
   end

   assign bus.cmd_err_o     = err;
   assign bus.step_en_o     = step_en;
   assign bus.step_cnt_o    = cnt;
   assign bus.busy_o        = busy;
   assign bus.halt_reason_o = reason;

endmodule

// File: tb/tb_tm_run_ctrl.sv
// Directed testbench for tm_run_ctrl (CNT_W=4 to reach saturation).
// Drives host commands and core step_done pulses, checks status outputs.
module tb_tm_run_ctrl;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   tm_run_ctrl_if #(.CNT_W(CW)) bus ();

   tm_run_ctrl #(.CNT_W(CW), .HALT_STATE(7'h7D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] c);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_i       = c;
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic done(input logic [6:0] st);
      bus.step_done_i = 1'b1;
      bus.tm_state_i  = st;
      tick();
      bus.step_done_i = 1'b0;
   endtask

   task automatic status(input string tag, input logic en, input logic bsy,
                         input logic [1:0] rsn, input logic [3:0] cnt);
      check({tag, ".en"},  32'(bus.step_en_o),     32'(en));
      check({tag, ".bsy"}, 32'(bus.busy_o),        32'(bsy));
      check({tag, ".rsn"}, 32'(bus.halt_reason_o), 32'(rsn));
      check({tag, ".cnt"}, 32'(bus.step_cnt_o),    32'(cnt));
   endtask

   localparam logic [1:0] CLR = 2'd0, RUN = 2'd1, STP = 2'd2, STOP = 2'd3;

   initial begin
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_i        = 2'd0;
      bus.step_done_i  = 1'b0;
      bus.tm_state_i   = 7'h00;
      bus.bp_en_i      = 1'b0;
      bus.bp_state_i   = 7'h00;
      bus.step_limit_i = '0;
      tick();
      tick();
      rst = 1'b0;
      status("rst", 0, 0, 0, 0);
      check("rst.err", 32'(bus.cmd_err_o), 0);

      // core halts at step 5
      cmd(RUN);
      status("run", 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) done(7'h01);
      status("run4", 1, 1, 0, 4);
      done(7'h7D);
      status("halt", 0, 0, 1, 5);
      cmd(RUN);
      check("halt.rerun.err", 32'(bus.cmd_err_o), 1);
      check("halt.rerun.en", 32'(bus.step_en_o), 0);
      tick();
      check("err.pulse", 32'(bus.cmd_err_o), 0);
      cmd(CLR);
      status("clr", 0, 0, 0, 0);

      // breakpoint then resume, then STOP mid-step
      bus.bp_en_i    = 1'b1;
      bus.bp_state_i = 7'h12;
      cmd(RUN);
      done(7'h01);
      done(7'h01);
      done(7'h12);
      status("bp", 0, 0, 2, 3);
      cmd(RUN);
      status("bp.resume", 1, 1, 0, 3);
      done(7'h13);
      status("bp.step4", 1, 1, 0, 4);
      cmd(STOP);
      status("drain", 0, 1, 0, 4);
      check("drain.err", 32'(bus.cmd_err_o), 0);
      cmd(RUN);
      check("drain.cmd.err", 32'(bus.cmd_err_o), 1);
      done(7'h01);
      status("drain.done", 0, 0, 0, 5);
      bus.bp_en_i = 1'b0;
      cmd(CLR);

      // step budget
      bus.step_limit_i = 4'd10;
      cmd(RUN);
      for (int i = 0; i < 9; i++) done(7'h01);
      status("lim9", 1, 1, 0, 9);
      done(7'h01);
      status("lim10", 0, 0, 3, 10);
      cmd(CLR);

      // unlimited run saturates without stopping
      bus.step_limit_i = 4'd0;
      cmd(RUN);
      for (int i = 0; i < 16; i++) done(7'h01);
      status("sat", 1, 1, 0, 15);
      cmd(STOP);
      done(7'h01);
      status("sat.stop", 0, 0, 0, 15);
      cmd(CLR);

      // single step
      cmd(STP);
      status("step", 1, 1, 0, 0);
      cmd(STP);
      check("step.again.err", 32'(bus.cmd_err_o), 1);
      check("step.again.en", 32'(bus.step_en_o), 1);
      done(7'h01);
      status("step.done", 0, 0, 0, 1);
      cmd(STOP);
      check("idle.stop.err", 32'(bus.cmd_err_o), 1);

      // STOP coinciding with a HALT step
      cmd(RUN);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_i       = STOP;
      bus.step_done_i = 1'b1;
      bus.tm_state_i  = 7'h7D;
      tick();
      bus.cmd_valid_i = 1'b0;
      bus.step_done_i = 1'b0;
      status("stop.halt", 0, 0, 1, 2);
      check("stop.halt.err", 32'(bus.cmd_err_o), 0);

      // reset in RUN
      cmd(CLR);
      cmd(RUN);
      done(7'h01);
      status("pre.rst", 1, 1, 0, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      status("mid.rst", 0, 0, 0, 0);
      check("mid.rst.err", 32'(bus.cmd_err_o), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
